ddr3_avl_arbiter: RTL and testbench

- Two-requester arbiter sharing one Avalon DDR3 controller port (sodimm1_ddr3_avl_*) between port 0 (VGA framebuffer fetch) and port 1 (pixel/CPU writer).
- Arbitrates per command and locks the grant for the full length of a write burst.
- Tracks outstanding reads in an in-order tag FIFO so each read-data beat is routed back to the port that issued it.

---
 rtl/ddr3_avl_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_ddr3_avl_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_avl_arbiter.sv
// Two-port arbiter in front of one Avalon DDR3 port, with an in-order read tag FIFO for return routing.
// Optional build macro ARB_FIXED_PRIO_EN: port 0 always wins in IDLE instead of round robin.
module ddr3_avl_arbiter #(
  parameter int TAG_PTR_DEPTH = 3,
  parameter int ADDR_W        = 26,
  parameter int DATA_W        = 128
) (
  input  logic              sodimm1_ddr3_avl_clk,
  input  logic              sodimm1_ddr3_avl_reset,
  input  logic              p0_read_req,
  input  logic              p0_write_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [2:0]        p0_size,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rdata_valid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_read_req,
  input  logic              p1_write_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [2:0]        p1_size,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rdata_valid,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              avl_ready,
  output logic              avl_burstbegin,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [2:0]        avl_size,
  output logic [DATA_W-1:0] avl_wdata,
  output logic              avl_read_req,
  output logic              avl_write_req,
  input  logic              avl_rdata_valid,
  input  logic [DATA_W-1:0] avl_rdata,
  output logic              rd_err
);

  localparam int TAG_DEPTH = 1 << TAG_PTR_DEPTH;
  localparam int PTR_W     = TAG_PTR_DEPTH + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WR_BURST = 1'b1} state_e;

  function automatic logic [2:0] eff_size(input logic [2:0] size);
    eff_size = (size == 3'd0) ? 3'd1 : size;
  endfunction

  logic clk, rst;
  assign clk = sodimm1_ddr3_avl_clk;
  assign rst = sodimm1_ddr3_avl_reset;

  state_e              state_q, state_d;
  logic                lock_port_q, lock_port_d;
  logic [2:0]          beats_left_q, beats_left_d;
  logic [ADDR_W-1:0]   burst_addr_q, burst_addr_d;
  logic [2:0]          burst_size_q, burst_size_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]          rd_beats_q, rd_beats_d;
  logic                rd_err_q, rd_err_d;
  logic [3:0]          tag_mem_q [TAG_DEPTH];
`ifndef ARB_FIXED_PRIO_EN
  logic                rr_last_q, rr_last_d;
`endif

  logic                tag_full_s, tag_empty_s, elig0_s, elig1_s;
  logic                grant_valid_s, grant_port_s;
  logic                sel_read_s, sel_write_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [2:0]          sel_size_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [3:0]          head_s;
  logic [2:0]          head_rem_s;
  logic                beat_ok_s, pop_s, push_s, acc_s;

  // Grant selection, request mux and read-tag head status (state and inputs only)
  always_comb begin
    tag_empty_s = (wr_ptr_q == rd_ptr_q);
    tag_full_s  = (wr_ptr_q[TAG_PTR_DEPTH] != rd_ptr_q[TAG_PTR_DEPTH]) &&
                  (wr_ptr_q[TAG_PTR_DEPTH-1:0] == rd_ptr_q[TAG_PTR_DEPTH-1:0]);
    // A read is only eligible while a tag slot is free; both-high counts as read
    elig0_s = (p0_read_req & ~tag_full_s) | (p0_write_req & ~p0_read_req);
    elig1_s = (p1_read_req & ~tag_full_s) | (p1_write_req & ~p1_read_req);
    grant_valid_s = 1'b0;
    grant_port_s  = 1'b0;
    if (state_q == ST_WR_BURST) begin
      grant_valid_s = 1'b1;
      grant_port_s  = lock_port_q;
    end else begin
`ifdef ARB_FIXED_PRIO_EN
      if (elig0_s) begin
        grant_valid_s = 1'b1;
        grant_port_s  = 1'b0;
      end else if (elig1_s) begin
        grant_valid_s = 1'b1;
        grant_port_s  = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_port_s  = 1'b0;
      end
`else
      if (elig0_s && elig1_s) begin
        grant_valid_s = 1'b1;
        grant_port_s  = ~rr_last_q;
      end else if (elig0_s) begin
        grant_valid_s = 1'b1;
        grant_port_s  = 1'b0;
      end else if (elig1_s) begin
        grant_valid_s = 1'b1;
        grant_port_s  = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_port_s  = 1'b0;
      end
`endif
    end
    sel_read_s  = grant_port_s ? p1_read_req  : p0_read_req;
    sel_write_s = grant_port_s ? p1_write_req : p0_write_req;
    sel_addr_s  = grant_port_s ? p1_addr      : p0_addr;
    sel_size_s  = grant_port_s ? p1_size      : p0_size;
    sel_wdata_s = grant_port_s ? p1_wdata     : p0_wdata;
    head_s      = tag_mem_q[rd_ptr_q[TAG_PTR_DEPTH-1:0]];
    head_rem_s  = (rd_beats_q == 3'd0) ? head_s[2:0] : rd_beats_q;
    beat_ok_s   = avl_rdata_valid & ~tag_empty_s;
    pop_s       = beat_ok_s & (head_rem_s == 3'd1);
  end

  // Output process: Avalon command mux, per-port ready and read-return steering
  always_comb begin
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_burstbegin = 1'b0;
    avl_addr       = sel_addr_s;
    avl_size       = sel_size_s;
    avl_wdata      = sel_wdata_s;
    p0_ready       = 1'b0;
    p1_ready       = 1'b0;
    p0_rdata_valid = 1'b0;
    p1_rdata_valid = 1'b0;
    if (rst) begin
      avl_read_req = 1'b0;
    end else if (state_q == ST_WR_BURST) begin
      avl_write_req  = sel_write_s;
      avl_addr       = burst_addr_q;
      avl_size       = burst_size_q;
      p0_ready       = avl_ready & ~lock_port_q;
      p1_ready       = avl_ready & lock_port_q;
      p0_rdata_valid = beat_ok_s & ~head_s[3];
      p1_rdata_valid = beat_ok_s & head_s[3];
    end else begin
      avl_read_req   = grant_valid_s & sel_read_s;
      avl_write_req  = grant_valid_s & sel_write_s & ~sel_read_s;
      avl_burstbegin = grant_valid_s;
      p0_ready       = avl_ready & grant_valid_s & ~grant_port_s;
      p1_ready       = avl_ready & grant_valid_s & grant_port_s;
      p0_rdata_valid = beat_ok_s & ~head_s[3];
      p1_rdata_valid = beat_ok_s & head_s[3];
    end
  end

  assign p0_rdata = avl_rdata;
  assign p1_rdata = avl_rdata;
  assign rd_err   = rd_err_q;
  assign acc_s    = avl_ready & (avl_read_req | avl_write_req);
  assign push_s   = (state_q == ST_IDLE) & acc_s & avl_read_req;

  // Next-state process: burst entry on a multi-beat first write, exit on the last beat
  always_comb begin
    state_d      = state_q;
    lock_port_d  = lock_port_q;
    beats_left_d = beats_left_q;
    burst_addr_d = burst_addr_q;
    burst_size_d = burst_size_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_s && avl_write_req && (eff_size(sel_size_s) != 3'd1)) begin
          state_d      = ST_WR_BURST;
          lock_port_d  = grant_port_s;
          beats_left_d = eff_size(sel_size_s) - 3'd1;
          burst_addr_d = sel_addr_s;
          burst_size_d = sel_size_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        if (acc_s) begin
          beats_left_d = beats_left_q - 3'd1;
          state_d      = (beats_left_q == 3'd1) ? ST_IDLE : ST_WR_BURST;
        end else begin
          state_d = ST_WR_BURST;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tag FIFO pointers, per-entry beat countdown and sticky orphan-beat flag
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push_s};
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop_s};
    rd_err_d = rd_err_q | (avl_rdata_valid & tag_empty_s);
    if (beat_ok_s) begin
      rd_beats_d = pop_s ? 3'd0 : (head_rem_s - 3'd1);
    end else begin
      rd_beats_d = rd_beats_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Burst and read-tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_port_q  <= 1'b0;
      beats_left_q <= 3'd0;
      burst_addr_q <= {ADDR_W{1'b0}};
      burst_size_q <= 3'd0;
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      rd_beats_q   <= 3'd0;
      rd_err_q     <= 1'b0;
    end else begin
      lock_port_q  <= lock_port_d;
      beats_left_q <= beats_left_d;
      burst_addr_q <= burst_addr_d;
      burst_size_q <= burst_size_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_beats_q   <= rd_beats_d;
      rd_err_q     <= rd_err_d;
    end
  end

  // Tag storage holds {port, effective size}; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push_s) tag_mem_q[wr_ptr_q[TAG_PTR_DEPTH-1:0]] <= {grant_port_s, eff_size(sel_size_s)};
  end

`ifndef ARB_FIXED_PRIO_EN
  // Round-robin history: the last port whose command was accepted in IDLE
  always_comb begin
    if ((state_q == ST_IDLE) && acc_s) rr_last_d = grant_port_s;
    else                               rr_last_d = rr_last_q;
  end

  // Round-robin history register; resets to 1 so port 0 wins first
  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end
`endif

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Directed bench for ddr3_avl_arbiter; read returns are checked against a queue of expected ports.
module tb_ddr3_avl_arbiter;
  localparam int AW = 26;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          p0_read_req, p0_write_req, p0_ready, p0_rdata_valid;
  logic [AW-1:0] p0_addr;
  logic [2:0]    p0_size;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_read_req, p1_write_req, p1_ready, p1_rdata_valid;
  logic [AW-1:0] p1_addr;
  logic [2:0]    p1_size;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          avl_ready, avl_burstbegin, avl_read_req, avl_write_req, avl_rdata_valid, rd_err;
  logic [AW-1:0] avl_addr;
  logic [2:0]    avl_size;
  logic [DW-1:0] avl_wdata, avl_rdata;

  int total = 0;
  int bad   = 0;
  int exp_q [$];

  ddr3_avl_arbiter dut (
    .sodimm1_ddr3_avl_clk  (clk),
    .sodimm1_ddr3_avl_reset(rst),
    .p0_read_req   (p0_read_req),
    .p0_write_req  (p0_write_req),
    .p0_addr       (p0_addr),
    .p0_size       (p0_size),
    .p0_wdata      (p0_wdata),
    .p0_ready      (p0_ready),
    .p0_rdata_valid(p0_rdata_valid),
    .p0_rdata      (p0_rdata),
    .p1_read_req   (p1_read_req),
    .p1_write_req  (p1_write_req),
    .p1_addr       (p1_addr),
    .p1_size       (p1_size),
    .p1_wdata      (p1_wdata),
    .p1_ready      (p1_ready),
    .p1_rdata_valid(p1_rdata_valid),
    .p1_rdata      (p1_rdata),
    .avl_ready     (avl_ready),
    .avl_burstbegin(avl_burstbegin),
    .avl_addr      (avl_addr),
    .avl_size      (avl_size),
    .avl_wdata     (avl_wdata),
    .avl_read_req  (avl_read_req),
    .avl_write_req (avl_write_req),
    .avl_rdata_valid(avl_rdata_valid),
    .avl_rdata     (avl_rdata),
    .rd_err        (rd_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                     input logic [2:0] s, input logic [DW-1:0] w);
    if (p == 0) begin
      p0_read_req = rd; p0_write_req = wr; p0_addr = a; p0_size = s; p0_wdata = w;
    end else begin
      p1_read_req = rd; p1_write_req = wr; p1_addr = a; p1_size = s; p1_wdata = w;
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compare the current beat against the oldest expected destination (or none)
  task automatic beat_check(input logic [DW-1:0] d);
    if (exp_q.size() == 0) begin
      chk1("orphan_rv0", p0_rdata_valid, 1'b0);
      chk1("orphan_rv1", p1_rdata_valid, 1'b0);
    end else begin
      int p;
      p = exp_q.pop_front();
      chk1("ret_rv0", p0_rdata_valid, p == 0);
      chk1("ret_rv1", p1_rdata_valid, p == 1);
      chkd("ret_data", (p == 0) ? p0_rdata : p1_rdata, d);
    end
  endtask

  task automatic ret_beat();
    logic [DW-1:0] d;
    d = rnd_data();
    avl_rdata_valid = 1'b1;
    avl_rdata = d;
    smp();
    beat_check(d);
    nxt();
    avl_rdata_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] d;
    logic [6:0]    rpat;
    int            nacc;
    int            eg;

    rst = 1'b1; avl_ready = 1'b1; avl_rdata_valid = 1'b0; avl_rdata = '0;
    drv(0, 1'b1, 1'b0, 26'h0, 3'd1, '0);
    drv(1, 1'b0, 1'b1, 26'h0, 3'd1, '0);
    nxt(); nxt(); smp();
    chk1("rst_p0_ready", p0_ready, 1'b0);
    chk1("rst_p1_ready", p1_ready, 1'b0);
    chk1("rst_rd_req", avl_read_req, 1'b0);
    chk1("rst_wr_req", avl_write_req, 1'b0);
    chk1("rst_bb", avl_burstbegin, 1'b0);
    chk1("rst_rd_err", rd_err, 1'b0);
    nxt();
    rst = 1'b0;

    // Both ports read size 2: p0 first, then p1; returns p0,p0,p1,p1
    drv(0, 1'b1, 1'b0, 26'h10, 3'd2, '0);
    drv(1, 1'b1, 1'b0, 26'h20, 3'd2, '0);
    smp();
    chk1("t1_p0_ready", p0_ready, 1'b1);
    chk1("t1_p1_wait", p1_ready, 1'b0);
    chk1("t1_rd_req", avl_read_req, 1'b1);
    chk1("t1_bb", avl_burstbegin, 1'b1);
    chka("t1_addr0", avl_addr, 26'h10);
    exp_q.push_back(0); exp_q.push_back(0);
    nxt();
    drv(0, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    smp();
    chk1("t1_p1_ready", p1_ready, 1'b1);
    chka("t1_addr1", avl_addr, 26'h20);
    exp_q.push_back(1); exp_q.push_back(1);
    nxt();
    drv(1, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    for (int i = 0; i < 4; i++) ret_beat();

    // p1 write burst of 4 at 0x100; p0 read waits until the burst ends
    w = rnd_data();
    drv(1, 1'b0, 1'b1, 26'h100, 3'd4, w);
    smp();
    chk1("t2_p1_ready0", p1_ready, 1'b1);
    chk1("t2_bb0", avl_burstbegin, 1'b1);
    chk1("t2_wr_req0", avl_write_req, 1'b1);
    chka("t2_addr0", avl_addr, 26'h100);
    chkd("t2_wdata0", avl_wdata, w);
    nxt();
    for (int i = 1; i < 4; i++) begin
      w = rnd_data();
      drv(1, 1'b0, 1'b1, 26'h3FF, 3'd4, w);
      drv(0, 1'b1, 1'b0, 26'h200, 3'd1, '0);
      smp();
      chk1("t2_p1_ready", p1_ready, 1'b1);
      chk1("t2_p0_locked_out", p0_ready, 1'b0);
      chk1("t2_bb", avl_burstbegin, 1'b0);
      chk1("t2_rd_req", avl_read_req, 1'b0);
      chka("t2_addr_hold", avl_addr, 26'h100);
      chkd("t2_wdata", avl_wdata, w);
      nxt();
    end
    drv(1, 1'b0, 1'b1, 26'h180, 3'd1, w);
    smp();
    chk1("t2_p0_granted", p0_ready, 1'b1);
    chk1("t2_p1_rr_wait", p1_ready, 1'b0);
    chk1("t2_p0_rd_req", avl_read_req, 1'b1);
    chk1("t2_p0_bb", avl_burstbegin, 1'b1);
    chka("t2_p0_addr", avl_addr, 26'h200);
    exp_q.push_back(0);
    nxt();
    drv(0, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    smp();
    chk1("t2_p1_single", p1_ready, 1'b1);
    chka("t2_p1_addr", avl_addr, 26'h180);
    nxt();
    drv(1, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    ret_beat();

    // p0 size-4 write with avl_ready 1,0,0,1,1,0,1
    rpat = 7'b1011001;
    nacc = 0;
    for (int i = 0; i < 7; i++) begin
      avl_ready = rpat[i];
      w = rnd_data();
      drv(0, 1'b0, 1'b1, (i == 0) ? 26'h100 : 26'h1FF, 3'd4, w);
      smp();
      chk1("t3_ready", p0_ready, rpat[i]);
      chka("t3_addr", avl_addr, 26'h100);
      chk1("t3_bb", avl_burstbegin, i == 0);
      chk1("t3_wr_req", avl_write_req, 1'b1);
      chkd("t3_wdata", avl_wdata, w);
      if (p0_ready && p0_write_req) nacc++;
      nxt();
    end
    chki("t3_beats", nacc, 4);
    avl_ready = 1'b1;
    drv(0, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    drv(1, 1'b1, 1'b0, 26'h300, 3'd1, '0);
    smp();
    chk1("t3_back_idle", p1_ready, 1'b1);
    chk1("t3_idle_bb", avl_burstbegin, 1'b1);
    exp_q.push_back(1);
    nxt();
    drv(1, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    ret_beat();

    // Fill all 8 tags; 9th read blocked until one beat pops a tag
    for (int i = 0; i < 8; i++) begin
      drv(0, 1'b1, 1'b0, 26'h400 + 26'(i), 3'd1, '0);
      smp();
      chk1("t4_fill_ready", p0_ready, 1'b1);
      exp_q.push_back(0);
      nxt();
    end
    w = rnd_data();
    drv(1, 1'b0, 1'b1, 26'h500, 3'd1, w);
    smp();
    chk1("t4_full_block", p0_ready, 1'b0);
    chk1("t4_full_rd_req", avl_read_req, 1'b0);
    chk1("t4_wr_bypass", p1_ready, 1'b1);
    chk1("t4_wr_req", avl_write_req, 1'b1);
    nxt();
    drv(1, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    smp();
    chk1("t4_still_full", p0_ready, 1'b0);
    nxt();
    d = rnd_data();
    avl_rdata_valid = 1'b1;
    avl_rdata = d;
    smp();
    chk1("t4_full_during_pop", p0_ready, 1'b0);
    beat_check(d);
    nxt();
    avl_rdata_valid = 1'b0;
    smp();
    chk1("t4_after_pop", p0_ready, 1'b1);
    exp_q.push_back(0);
    nxt();
    drv(0, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    for (int i = 0; i < 8; i++) ret_beat();

    // Reset in the middle of a p1 burst with one read outstanding
    drv(0, 1'b1, 1'b0, 26'h600, 3'd1, '0);
    smp();
    chk1("t5_read_ready", p0_ready, 1'b1);
    nxt();
    drv(0, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    drv(1, 1'b0, 1'b1, 26'h700, 3'd4, rnd_data());
    smp();
    chk1("t5_burst_b0", p1_ready, 1'b1);
    nxt();
    smp();
    chk1("t5_burst_b1", p1_ready, 1'b1);
    nxt();
    rst = 1'b1;
    smp();
    chk1("t5_rst_wr_req", avl_write_req, 1'b0);
    chk1("t5_rst_p1_ready", p1_ready, 1'b0);
    chk1("t5_rst_bb", avl_burstbegin, 1'b0);
    nxt();
    rst = 1'b0;
    drv(1, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    ret_beat();
    w = rnd_data();
    drv(0, 1'b0, 1'b1, 26'h800, 3'd1, w);
    smp();
    chk1("t5_rd_err_set", rd_err, 1'b1);
    chk1("t5_burst_aborted", p0_ready, 1'b1);
    chk1("t5_idle_bb", avl_burstbegin, 1'b1);
    nxt();
    drv(0, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    nxt(); nxt();
    smp();
    chk1("t5_rd_err_sticky", rd_err, 1'b1);
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    smp();
    chk1("t5_rd_err_cleared", rd_err, 1'b0);
    nxt();

    // Both ports stream size-1 writes: alternate, or port 0 only with fixed priority
    for (int i = 0; i < 4; i++) begin
      drv(0, 1'b0, 1'b1, 26'h900, 3'd1, rnd_data());
      drv(1, 1'b0, 1'b1, 26'hA00, 3'd1, rnd_data());
      smp();
`ifdef ARB_FIXED_PRIO_EN
      eg = 0;
`else
      eg = i % 2;
`endif
      chk1("t6_p0_grant", p0_ready, eg == 0);
      chk1("t6_p1_grant", p1_ready, eg == 1);
      chka("t6_addr", avl_addr, (eg == 0) ? 26'h900 : 26'hA00);
      nxt();
    end
    drv(0, 1'b0, 1'b0, 26'h0, 3'd1, '0);
    drv(1, 1'b0, 1'b0, 26'h0, 3'd1, '0);

    chki("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
